// File: rtl/neuron_input_feeder.sv
// Serial-to-parallel feeder for a neuron input vector: gathers NUM_INPUTS signed
// samples over valid/ready, announces the vector once, then holds it until the neuron finishes.
module neuron_input_feeder #(
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_INPUTS        = 16,
    parameter int TIMEOUT_CYCLES    = 1024,
    parameter int FRAME_COUNT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
    output logic                         input_ready,
    input  logic                         output_ready,
    output logic                         busy,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
    output logic                         timeout_error
);

    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INPUTS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_FILLING = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2
    } state_t;

    state_t                          state_q;
    logic [IDX_W-1:0]                idx_q;
    logic [WD_W-1:0]                 wd_q;
    logic [FRAME_COUNT_WIDTH-1:0]    frame_q;
    logic                            err_q;
    logic                            in_ready_q;
    logic                            input_ready_q;
    logic                            busy_q;
    logic signed [DATA_WIDTH-1:0]    vec_q [NUM_INPUTS];

    // Feeder FSM: handshake outputs are registered alongside the state they decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_FILLING;
            idx_q         <= '0;
            wd_q          <= '0;
            frame_q       <= '0;
            err_q         <= 1'b0;
            in_ready_q    <= 1'b1;
            input_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FILLING: begin
                    // in_ready is high throughout FILLING, so in_valid alone is the handshake
                    if (in_valid) begin
                        vec_q[idx_q] <= in_data;
                        if (idx_q == IDX_LAST) begin
                            idx_q         <= '0;
                            state_q       <= S_ISSUE;
                            in_ready_q    <= 1'b0;
                            input_ready_q <= 1'b1;
                            busy_q        <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    wd_q          <= '0;
                    state_q       <= S_WAIT;
                    input_ready_q <= 1'b0;
                end
                S_WAIT: begin
                    if (output_ready) begin
                        frame_q    <= frame_q + 1'b1;
                        state_q    <= S_FILLING;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (wd_q == WD_LAST) begin
                            err_q      <= 1'b1;
                            state_q    <= S_FILLING;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q       <= S_FILLING;
                    idx_q         <= '0;
                    in_ready_q    <= 1'b1;
                    input_ready_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign input_ready   = input_ready_q;
    assign busy          = busy_q;
    assign frame_count   = frame_q;
    assign timeout_error = err_q;
    assign inputs        = vec_q;

endmodule

// File: tb/tb_neuron_input_feeder.sv
// Directed bench for neuron_input_feeder: a 4x8-bit main instance with 2-bit frame
// counter, and a second instance with an 8-cycle watchdog for the timeout scenario.
module tb_neuron_input_feeder;

    logic              clock;
    logic              reset;

    logic signed [7:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] vec [4];
    logic              input_ready;
    logic              output_ready;
    logic              busy;
    logic [1:0]        frame_count;
    logic              timeout_error;

    logic signed [7:0] t_in_data;
    logic              t_in_valid;
    logic              t_in_ready;
    logic signed [7:0] t_vec [4];
    logic              t_input_ready;
    logic              t_output_ready;
    logic              t_busy;
    logic [15:0]       t_frame_count;
    logic              t_timeout_error;

    int tests;
    int fails;

    neuron_input_feeder #(
        .DATA_WIDTH(8), .NUM_INPUTS(4), .TIMEOUT_CYCLES(64), .FRAME_COUNT_WIDTH(2)
    ) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .inputs(vec), .input_ready(input_ready), .output_ready(output_ready),
        .busy(busy), .frame_count(frame_count), .timeout_error(timeout_error)
    );

    neuron_input_feeder #(
        .DATA_WIDTH(8), .NUM_INPUTS(4), .TIMEOUT_CYCLES(8), .FRAME_COUNT_WIDTH(16)
    ) dut_t (
        .clock(clock), .reset(reset),
        .in_data(t_in_data), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .inputs(t_vec), .input_ready(t_input_ready), .output_ready(t_output_ready),
        .busy(t_busy), .frame_count(t_frame_count), .timeout_error(t_timeout_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_t(input logic signed [7:0] d);
        t_in_valid = 1'b1;
        t_in_data  = d;
        step();
        t_in_valid = 1'b0;
    endtask

    task automatic check_vec(input string tag, input logic signed [7:0] a, input logic signed [7:0] b,
                             input logic signed [7:0] c, input logic signed [7:0] d);
        check({tag, "_v0"}, 16'(vec[0]), 16'(a));
        check({tag, "_v1"}, 16'(vec[1]), 16'(b));
        check({tag, "_v2"}, 16'(vec[2]), 16'(c));
        check({tag, "_v3"}, 16'(vec[3]), 16'(d));
    endtask

    task automatic run_frame(input logic signed [7:0] base, input logic [1:0] exp_fc);
        send(base);
        send(base + 8'sd1);
        send(base + 8'sd2);
        send(base + 8'sd3);
        check("frame_issue", 16'(input_ready), 16'd1);
        step();
        output_ready = 1'b1;
        step();
        output_ready = 1'b0;
        check("frame_count", 16'(frame_count), 16'(exp_fc));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        in_data = '0; in_valid = 1'b0; output_ready = 1'b0;
        t_in_data = '0; t_in_valid = 1'b0; t_output_ready = 1'b0;
        step();
        step();

        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_input_ready", 16'(input_ready), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_frame_count", 16'(frame_count), 16'd0);
        check("rst_timeout", 16'(timeout_error), 16'd0);
        check_vec("rst", 8'sd0, 8'sd0, 8'sd0, 8'sd0);
        reset = 1'b0;
        step();

        // Back-to-back stream 1,2,3,-4
        send(8'sd1);
        send(8'sd2);
        send(8'sd3);
        check("fill_in_ready", 16'(in_ready), 16'd1);
        check("fill_no_issue", 16'(input_ready), 16'd0);
        send(-8'sd4);
        check("issue_pulse", 16'(input_ready), 16'd1);
        check("issue_in_ready", 16'(in_ready), 16'd0);
        check("issue_busy", 16'(busy), 16'd1);
        step();
        check("wait_pulse_gone", 16'(input_ready), 16'd0);
        check("wait_busy", 16'(busy), 16'd1);
        check_vec("stream1", 8'sd1, 8'sd2, 8'sd3, -8'sd4);

        // Source pushes 99 while the vector is held
        in_valid = 1'b1;
        in_data  = 8'sd99;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_v0", 16'(vec[0]), 16'(8'sd1));
            check("hold_v3", 16'(vec[3]), 16'(-8'sd4));
            check("hold_in_ready", 16'(in_ready), 16'd0);
        end
        in_valid = 1'b0;
        output_ready = 1'b1;
        step();
        output_ready = 1'b0;
        check("done_frame_count", 16'(frame_count), 16'd1);
        check("done_in_ready", 16'(in_ready), 16'd1);
        check("done_busy", 16'(busy), 16'd0);

        // Next frame starts at inputs[0], with a 3-cycle gap after sample 2
        send(8'sd42);
        check("next_v0", 16'(vec[0]), 16'(8'sd42));
        check("next_v1_old", 16'(vec[1]), 16'(8'sd2));
        send(8'sd43);
        for (int i = 0; i < 3; i++) begin
            step();
            check("gap_in_ready", 16'(in_ready), 16'd1);
            check("gap_no_issue", 16'(input_ready), 16'd0);
            check("gap_v2_old", 16'(vec[2]), 16'(8'sd3));
        end
        send(8'sd44);
        check("gap_no_early_issue", 16'(input_ready), 16'd0);
        send(-8'sd45);
        check("gap_issue", 16'(input_ready), 16'd1);
        check_vec("gap", 8'sd42, 8'sd43, 8'sd44, -8'sd45);
        step();
        output_ready = 1'b1;
        step();
        output_ready = 1'b0;
        check("fc_2", 16'(frame_count), 16'd2);

        // Frame counter wraps at 2 bits
        run_frame(8'sd10, 2'd3);
        run_frame(8'sd20, 2'd0);
        run_frame(8'sd30, 2'd1);

        // output_ready during FILLING and ISSUE is ignored
        output_ready = 1'b1;
        step();
        output_ready = 1'b0;
        check("ign_fill_fc", 16'(frame_count), 16'd1);
        check("ign_fill_in_ready", 16'(in_ready), 16'd1);
        send(8'sd1);
        send(8'sd2);
        send(8'sd3);
        in_valid = 1'b1;
        in_data = 8'sd4;
        output_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("ign_issue_state", 16'(input_ready), 16'd1);
        step();
        output_ready = 1'b0;
        check("ign_issue_fc", 16'(frame_count), 16'd1);
        check("ign_issue_busy", 16'(busy), 16'd1);
        output_ready = 1'b1;
        step();
        output_ready = 1'b0;
        check("after_ign_fc", 16'(frame_count), 16'd2);

        // Reset in mid-frame discards the partial vector
        send(8'sd77);
        send(8'sd78);
        reset = 1'b1;
        #1;
        check("mid_rst_v0", 16'(vec[0]), 16'd0);
        check("mid_rst_v1", 16'(vec[1]), 16'd0);
        check("mid_rst_fc", 16'(frame_count), 16'd0);
        check("mid_rst_in_ready", 16'(in_ready), 16'd1);
        step();
        reset = 1'b0;
        send(8'sd5);
        send(8'sd6);
        send(8'sd7);
        check("post_rst_no_issue", 16'(input_ready), 16'd0);
        send(8'sd8);
        check("post_rst_issue", 16'(input_ready), 16'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_single_pulse", 16'(input_ready), 16'd0);
        end
        check_vec("post_rst", 8'sd5, 8'sd6, 8'sd7, 8'sd8);
        output_ready = 1'b1;
        step();
        output_ready = 1'b0;
        check("post_rst_fc", 16'(frame_count), 16'd1);

        // Watchdog: 8 WAIT cycles without output_ready
        send_t(8'sd11);
        send_t(8'sd12);
        send_t(8'sd13);
        send_t(8'sd14);
        check("t_issue", 16'(t_input_ready), 16'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t_wait_no_err", 16'(t_timeout_error), 16'd0);
            check("t_wait_busy", 16'(t_busy), 16'd1);
        end
        step();
        check("t_err_set", 16'(t_timeout_error), 16'd1);
        check("t_err_in_ready", 16'(t_in_ready), 16'd1);
        check("t_err_busy", 16'(t_busy), 16'd0);
        check("t_err_fc", 16'(t_frame_count), 16'd0);
        send_t(8'sd21);
        send_t(8'sd22);
        send_t(8'sd23);
        send_t(8'sd24);
        check("t2_issue", 16'(t_input_ready), 16'd1);
        check("t2_err_sticky", 16'(t_timeout_error), 16'd1);
        check("t2_v3", 16'(t_vec[3]), 16'(8'sd24));
        step();
        t_output_ready = 1'b1;
        step();
        t_output_ready = 1'b0;
        check("t2_fc", 16'(t_frame_count), 16'd1);
        check("t2_err_still", 16'(t_timeout_error), 16'd1);
        check("t2_in_ready", 16'(t_in_ready), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
